// File: rtl/present_sbox_layer_seq.sv
// Feeds a 3-share 64-bit PRESENT state through an external pipelined masked S-box,
// one nibble per cycle, and reassembles the output shares. Optional: RND_ERR_EN (rnd_err).
module present_sbox_layer_seq #(
    parameter int SBOX_LAT = 5,
    parameter int RND_W    = 24
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_s1,
    input  logic [63:0]      in_s2,
    input  logic [63:0]      in_s3,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd_in,
    output logic [3:0]       sbox_in1,
    output logic [3:0]       sbox_in2,
    output logic [3:0]       sbox_in3,
    output logic [RND_W-1:0] sbox_r,
    input  logic [3:0]       sbox_out1,
    input  logic [3:0]       sbox_out2,
    input  logic [3:0]       sbox_out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s1,
    output logic [63:0]      out_s2,
    output logic [63:0]      out_s3
`ifdef RND_ERR_EN
    ,
    output logic             rnd_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          issue_cnt_q, issue_cnt_d;
    logic [3:0]          cap_cnt_q, cap_cnt_d;
    logic [SBOX_LAT-1:0] tag_q, tag_d;
    logic [63:0]         buf1_q, buf1_d, buf2_q, buf2_d, buf3_q, buf3_d;
    logic [63:0]         out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic [3:0]          sin1_q, sin1_d, sin2_q, sin2_d, sin3_q, sin3_d;
    logic [RND_W-1:0]    sr_q, sr_d;
    logic                push;
`ifdef RND_ERR_EN
    logic                rnd_err_q, rnd_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        buf1_d      = buf1_q;
        buf2_d      = buf2_q;
        buf3_d      = buf3_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        sin1_d      = 4'h0;
        sin2_d      = 4'h0;
        sin3_d      = 4'h0;
        sr_d        = '0;
        push        = 1'b0;
        rnd_ready   = 1'b0;
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf1_d      = in_s1;
                    buf2_d      = in_s2;
                    buf3_d      = in_s3;
                    issue_cnt_d = 4'h0;
                    cap_cnt_d   = 4'h0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (rnd_valid) begin
                    sin1_d      = buf1_q[{issue_cnt_q, 2'b00} +: 4];
                    sin2_d      = buf2_q[{issue_cnt_q, 2'b00} +: 4];
                    sin3_d      = buf3_q[{issue_cnt_q, 2'b00} +: 4];
                    push        = 1'b1;
                    rnd_ready   = 1'b1;
                    issue_cnt_d = issue_cnt_q + 4'd1;
                    if (issue_cnt_q == 4'hF) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // later S-box stages still remask, so randomness keeps flowing
                rnd_ready = rnd_valid;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == ISSUE || state_q == DRAIN) begin
`ifdef RND_ERR_EN
            sr_d = rnd_valid ? rnd_in : '0;
`else
            sr_d = rnd_in;
`endif
            // the oldest tag marks a real nibble arriving from the S-box this cycle
            if (tag_q[SBOX_LAT-1]) begin
                out1_d[{cap_cnt_q, 2'b00} +: 4] = sbox_out1;
                out2_d[{cap_cnt_q, 2'b00} +: 4] = sbox_out2;
                out3_d[{cap_cnt_q, 2'b00} +: 4] = sbox_out3;
                cap_cnt_d = cap_cnt_q + 4'd1;
                if (state_q == DRAIN && cap_cnt_q == 4'hF) state_d = DONE;
            end
        end

        tag_d = SBOX_LAT'({tag_q, push});

`ifdef RND_ERR_EN
        rnd_err_d = rnd_err_q | (~rnd_valid & (|tag_q));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            issue_cnt_q <= 4'h0;
            cap_cnt_q   <= 4'h0;
            tag_q       <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            sin1_q      <= 4'h0;
            sin2_q      <= 4'h0;
            sin3_q      <= 4'h0;
            sr_q        <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            tag_q       <= tag_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            sin1_q      <= sin1_d;
            sin2_q      <= sin2_d;
            sin3_q      <= sin3_d;
            sr_q        <= sr_d;
        end
    end

    // input share buffer carries no control meaning, so it is left out of reset
    always_ff @(posedge clk) begin
        buf1_q <= buf1_d;
        buf2_q <= buf2_d;
        buf3_q <= buf3_d;
    end

`ifdef RND_ERR_EN
    always_ff @(posedge clk) begin
        if (rst_i) rnd_err_q <= 1'b0;
        else       rnd_err_q <= rnd_err_d;
    end
    assign rnd_err = rnd_err_q;
`endif

    assign sbox_in1 = sin1_q;
    assign sbox_in2 = sin2_q;
    assign sbox_in3 = sin3_q;
    assign sbox_r   = sr_q;
    assign out_s1   = out1_q;
    assign out_s2   = out2_q;
    assign out_s3   = out3_q;

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Directed bench for present_sbox_layer_seq with a 5-cycle reference masked S-box model.
module tb_present_sbox_layer_seq;
    localparam int RND_W = 24;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'hC56B90AD3EF84712;
    localparam logic [63:0] PTF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] CTF = 64'h2222222222222222;
    localparam logic [63:0] CTZ = 64'hCCCCCCCCCCCCCCCC;

    logic             clk;
    logic             rst_i;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_s1, in_s2, in_s3;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd_in;
    logic [3:0]       sbox_in1, sbox_in2, sbox_in3;
    logic [RND_W-1:0] sbox_r;
    logic [3:0]       sbox_out1, sbox_out2, sbox_out3;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_s1, out_s2, out_s3;
`ifdef RND_ERR_EN
    logic             rnd_err;
`endif

    int errs;
    int checks;

    present_sbox_layer_seq #(.SBOX_LAT(5), .RND_W(RND_W)) dut (
        .clk(clk), .rst_i(rst_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
        .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
        .sbox_r(sbox_r),
        .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3)
`ifdef RND_ERR_EN
        , .rnd_err(rnd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] present_s(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    // Reference S-box: 4 register stages, so an input driven after edge t reaches
    // the output during the cycle ending at edge t+5. Output re-shared with two masks.
    logic [11:0] pipe [4];
    always @(posedge clk) begin
        pipe[0] <= {present_s(sbox_in1 ^ sbox_in2 ^ sbox_in3) ^ sbox_r[3:0] ^ sbox_r[7:4],
                    sbox_r[3:0], sbox_r[7:4]};
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign sbox_out1 = pipe[3][11:8];
    assign sbox_out2 = pipe[3][7:4];
    assign sbox_out3 = pipe[3][3:0];

    task automatic start_layer(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_s1 = a; in_s2 = b; in_s3 = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles until out_valid (0 on timeout).
    task automatic wait_done(input bit stalls, output int lat, output int irdy_hi);
        lat = 0;
        irdy_hi = 0;
        rnd_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            rnd_in = RND_W'($urandom);
            if (out_valid) begin
                lat = c;
                break;
            end
            if (in_ready) irdy_hi++;
            rnd_valid = !(stalls && (c + 1 == 3 || c + 1 == 4 || c + 1 == 10));
        end
        rnd_valid = 1'b1;
    endtask

    task automatic finish_layer;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (rnd_ready !== 1'b0) begin errs++; $display("FAIL reset_rnd_ready got=%b exp=0", rnd_ready); end
        checks++; if (out_s1 !== 64'h0) begin errs++; $display("FAIL reset_out_s1 got=%h exp=0", out_s1); end
        checks++; if (out_s2 !== 64'h0) begin errs++; $display("FAIL reset_out_s2 got=%h exp=0", out_s2); end
        checks++; if (out_s3 !== 64'h0) begin errs++; $display("FAIL reset_out_s3 got=%h exp=0", out_s3); end
        checks++; if ((sbox_in1 | sbox_in2 | sbox_in3) !== 4'h0) begin errs++; $display("FAIL reset_sbox_in got=%h%h%h exp=000", sbox_in1, sbox_in2, sbox_in3); end
        checks++; if (sbox_r !== '0) begin errs++; $display("FAIL reset_sbox_r got=%h exp=0", sbox_r); end
`ifdef RND_ERR_EN
        checks++; if (rnd_err !== 1'b0) begin errs++; $display("FAIL reset_rnd_err got=%b exp=0", rnd_err); end
`endif
    endtask

    task automatic test_unmasked;
        int lat, hi;
        start_layer(PT, 64'h0, 64'h0);
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) begin errs++; $display("FAIL unmasked_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CT); end
        checks++; if (lat !== 21) begin errs++; $display("FAIL unmasked_latency got=%0d exp=21", lat); end
        finish_layer();
    endtask

    task automatic test_masked;
        int lat, hi;
        logic [63:0] m2, m3;
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        start_layer(PT ^ m2 ^ m3, m2, m3);
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) begin errs++; $display("FAIL masked_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CT); end
        checks++; if (lat !== 21) begin errs++; $display("FAIL masked_latency got=%0d exp=21", lat); end
        checks++; if (hi !== 0) begin errs++; $display("FAIL masked_in_ready_busy got=%0d cycles high exp=0", hi); end
        finish_layer();
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL masked_idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_rnd_stall;
        int lat, hi;
        logic [63:0] m2, m3;
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        start_layer(PT ^ m2 ^ m3, m2, m3);
        wait_done(1'b1, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) begin errs++; $display("FAIL stall_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CT); end
        checks++; if (lat !== 24) begin errs++; $display("FAIL stall_latency got=%0d exp=24", lat); end
`ifdef RND_ERR_EN
        checks++; if (rnd_err !== 1'b1) begin errs++; $display("FAIL stall_rnd_err got=%b exp=1", rnd_err); end
`endif
        finish_layer();
    endtask

    task automatic test_backpressure;
        int lat, hi, unstable, busy;
        logic [63:0] m2, m3, h1, h2, h3;
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        start_layer(PTF ^ m2 ^ m3, m2, m3);
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CTF) begin errs++; $display("FAIL bp_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CTF); end
        h1 = out_s1; h2 = out_s2; h3 = out_s3;
        unstable = 0;
        busy = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            rnd_in = RND_W'($urandom);
            if (out_s1 !== h1 || out_s2 !== h2 || out_s3 !== h3 || out_valid !== 1'b1) unstable++;
            if (in_ready !== 1'b0) busy++;
        end
        checks++; if (unstable !== 0) begin errs++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", unstable); end
        checks++; if (busy !== 0) begin errs++; $display("FAIL bp_in_ready got=%0d cycles high exp=0", busy); end
        finish_layer();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_out_valid_drop got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid;
        int lat, hi;
        logic [63:0] m2, m3;
        start_layer(PT, 64'h0, 64'h0);
        rnd_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if ((out_s1 | out_s2 | out_s3) !== 64'h0) begin errs++; $display("FAIL rstmid_out_s got=%h exp=0", out_s1 | out_s2 | out_s3); end
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        start_layer(PTF ^ m2 ^ m3, m2, m3);
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CTF) begin errs++; $display("FAIL rstmid_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CTF); end
        checks++; if (lat !== 21) begin errs++; $display("FAIL rstmid_latency got=%0d exp=21", lat); end
        finish_layer();
    endtask

    task automatic test_back_to_back;
        int lat, hi;
        logic [63:0] m2, m3;
        start_layer(PT, 64'h0, 64'h0);
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CT) begin errs++; $display("FAIL b2b_first_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CT); end
        m2 = {$urandom, $urandom};
        m3 = {$urandom, $urandom};
        in_s1 = m2 ^ m3; in_s2 = m2; in_s3 = m3;
        in_valid = 1'b1;
        finish_layer();
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_idle got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_accept got=%b exp=0", in_ready); end
        wait_done(1'b0, lat, hi);
        checks++; if ((out_s1 ^ out_s2 ^ out_s3) !== CTZ) begin errs++; $display("FAIL b2b_second_result got=%h exp=%h", out_s1 ^ out_s2 ^ out_s3, CTZ); end
        checks++; if (lat !== 21) begin errs++; $display("FAIL b2b_second_latency got=%0d exp=21", lat); end
        finish_layer();
    endtask

    initial begin
        errs = 0;
        checks = 0;
        rst_i = 1'b1;
        in_valid = 1'b0;
        in_s1 = '0; in_s2 = '0; in_s3 = '0;
        rnd_valid = 1'b1;
        rnd_in = '0;
        out_ready = 1'b0;
        test_reset();
        test_unmasked();
        test_masked();
        test_rnd_stall();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
